// File: rtl/vx_commit_arbiter_pkg.sv
// Shared definitions for the commit arbiter: source indices, bundle widths
// and the packed beat record that one execution unit presents per cycle.
package vx_commit_arbiter_pkg;

    localparam int NUM_REQS    = 5;
    localparam int NUM_THREADS = 4;
    localparam int NUM_WARPS   = 4;
    localparam int NW_BITS     = $clog2(NUM_WARPS);
    localparam int NR_BITS     = 6;
    localparam int UUID_BITS   = 44;
    localparam int SRC_BITS    = $clog2(NUM_REQS);
    localparam int DATA_BITS   = NUM_THREADS * 32;

    localparam logic [SRC_BITS-1:0] CMT_ALU = 3'd0;
    localparam logic [SRC_BITS-1:0] CMT_LSU = 3'd1;
    localparam logic [SRC_BITS-1:0] CMT_CSR = 3'd2;
    localparam logic [SRC_BITS-1:0] CMT_FPU = 3'd3;
    localparam logic [SRC_BITS-1:0] CMT_GPU = 3'd4;

    typedef struct packed {
        logic [UUID_BITS-1:0]   uuid;
        logic [NW_BITS-1:0]     wid;
        logic [NUM_THREADS-1:0] tmask;
        logic [31:0]            PC;
        logic [NR_BITS-1:0]     rd;
        logic                   wb;
        logic                   eop;
        logic [DATA_BITS-1:0]   data;
    } cmt_beat_t;

endpackage

// File: rtl/vx_rr_lock_arbiter.sv
// Round-robin selector with an instruction lock: once a source delivers a
// non-final beat, it stays the only candidate until its final beat fires.
module vx_rr_lock_arbiter #(
    parameter int N = 5,
    localparam int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  req_valid,
    input  logic          fire,
    input  logic          fire_eop,
    output logic [IW-1:0] cand,
    output logic          cand_valid
);

    localparam int PW = IW + 1;

    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] lock_src;
    logic          lock_valid;
    logic [PW-1:0] probe;

    // Pick the locked source, or the first valid source at/after rr_ptr with wrap.
    always_comb begin
        cand       = lock_src;
        cand_valid = req_valid[lock_src];
        probe      = '0;
        if (!lock_valid) begin
            cand       = rr_ptr;
            cand_valid = 1'b0;
            for (int k = 0; k < N; k++) begin
                probe = {1'b0, rr_ptr} + PW'(k);
                if (probe >= PW'(N))
                    probe = probe - PW'(N);
                if (!cand_valid && req_valid[probe[IW-1:0]]) begin
                    cand       = probe[IW-1:0];
                    cand_valid = 1'b1;
                end
            end
        end
    end

    // Advance the pointer past a finished instruction, or lock onto a partial one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr     <= '0;
            lock_valid <= 1'b0;
            lock_src   <= '0;
        end else if (fire) begin
            if (fire_eop) begin
                lock_valid <= 1'b0;
                rr_ptr     <= (cand == IW'(N - 1)) ? '0 : cand + 1'b1;
            end else begin
                lock_valid <= 1'b1;
                lock_src   <= cand;
            end
        end
    end

endmodule

// File: rtl/vx_commit_arbiter.sv
// Commit arbiter: serialises the five execution-unit result streams onto the
// single GPR writeback port through one registered ready/valid stage.
// Optional build macro VX_COMMIT_PERF_EN adds perf_commits/perf_stalls counters.
module vx_commit_arbiter
    import vx_commit_arbiter_pkg::*;
(
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_REQS-1:0]             cmt_valid,
    output logic [NUM_REQS-1:0]             cmt_ready,
    input  logic [NUM_REQS*UUID_BITS-1:0]   cmt_uuid,
    input  logic [NUM_REQS*NW_BITS-1:0]     cmt_wid,
    input  logic [NUM_REQS*NUM_THREADS-1:0] cmt_tmask,
    input  logic [NUM_REQS*32-1:0]          cmt_PC,
    input  logic [NUM_REQS*NR_BITS-1:0]     cmt_rd,
    input  logic [NUM_REQS-1:0]             cmt_wb,
    input  logic [NUM_REQS-1:0]             cmt_eop,
    input  logic [NUM_REQS*DATA_BITS-1:0]   cmt_data,
    output logic                            wb_valid,
    input  logic                            wb_ready,
    output logic [UUID_BITS-1:0]            wb_uuid,
    output logic [NW_BITS-1:0]              wb_wid,
    output logic [NUM_THREADS-1:0]          wb_tmask,
    output logic [31:0]                     wb_PC,
    output logic [NR_BITS-1:0]              wb_rd,
    output logic                            wb_eop,
    output logic [DATA_BITS-1:0]            wb_data,
    output logic [SRC_BITS-1:0]             wb_src
`ifdef VX_COMMIT_PERF_EN
    ,
    output logic [63:0]                     perf_commits,
    output logic [63:0]                     perf_stalls
`endif
);

    cmt_beat_t           beats [NUM_REQS];
    cmt_beat_t           sel;
    logic [SRC_BITS-1:0] cand;
    logic                cand_valid;
    logic                can_accept;
    logic                grant;

    for (genvar g = 0; g < NUM_REQS; g++) begin : g_unpack
        assign beats[g] = {cmt_uuid[g*UUID_BITS +: UUID_BITS],
                           cmt_wid[g*NW_BITS +: NW_BITS],
                           cmt_tmask[g*NUM_THREADS +: NUM_THREADS],
                           cmt_PC[g*32 +: 32],
                           cmt_rd[g*NR_BITS +: NR_BITS],
                           cmt_wb[g],
                           cmt_eop[g],
                           cmt_data[g*DATA_BITS +: DATA_BITS]};
    end

    vx_rr_lock_arbiter #(
        .N (NUM_REQS)
    ) u_arb (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (cmt_valid),
        .fire       (grant),
        .fire_eop   (sel.eop),
        .cand       (cand),
        .cand_valid (cand_valid)
    );

    assign sel        = beats[cand];
    assign can_accept = !wb_valid || wb_ready;
    // Beats that do not write rd never need the output stage, so they bypass backpressure.
    assign grant      = cand_valid && (sel.wb ? can_accept : 1'b1);

    // Only the candidate source can see ready.
    always_comb begin
        cmt_ready       = '0;
        cmt_ready[cand] = grant;
    end

    // Output stage: load an accepted writing beat, otherwise drain when the GPR port takes it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wb_valid <= 1'b0;
            wb_uuid  <= '0;
            wb_wid   <= '0;
            wb_tmask <= '0;
            wb_PC    <= '0;
            wb_rd    <= '0;
            wb_eop   <= 1'b0;
            wb_data  <= '0;
            wb_src   <= '0;
        end else if (grant && sel.wb) begin
            wb_valid <= 1'b1;
            wb_uuid  <= sel.uuid;
            wb_wid   <= sel.wid;
            wb_tmask <= sel.tmask;
            wb_PC    <= sel.PC;
            wb_rd    <= sel.rd;
            wb_eop   <= sel.eop;
            wb_data  <= sel.data;
            wb_src   <= cand;
        end else if (wb_ready) begin
            wb_valid <= 1'b0;
        end
    end

`ifdef VX_COMMIT_PERF_EN
    // Count finished instructions and cycles where pending results could not move.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_commits <= '0;
            perf_stalls  <= '0;
        end else begin
            if (grant && sel.eop)
                perf_commits <= perf_commits + 64'd1;
            if ((|cmt_valid) && !grant)
                perf_stalls <= perf_stalls + 64'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vx_commit_arbiter.sv
// Directed bench for vx_commit_arbiter: a vector table for the arbitration
// order, lock and backpressure, plus hand sequences for reset and hold.
module tb_vx_commit_arbiter;
    import vx_commit_arbiter_pkg::*;

    logic                            clk = 1'b0;
    logic                            reset;
    logic [NUM_REQS-1:0]             cmt_valid;
    logic [NUM_REQS-1:0]             cmt_ready;
    logic [NUM_REQS*UUID_BITS-1:0]   cmt_uuid;
    logic [NUM_REQS*NW_BITS-1:0]     cmt_wid;
    logic [NUM_REQS*NUM_THREADS-1:0] cmt_tmask;
    logic [NUM_REQS*32-1:0]          cmt_PC;
    logic [NUM_REQS*NR_BITS-1:0]     cmt_rd;
    logic [NUM_REQS-1:0]             cmt_wb;
    logic [NUM_REQS-1:0]             cmt_eop;
    logic [NUM_REQS*DATA_BITS-1:0]   cmt_data;
    logic                            wb_valid;
    logic                            wb_ready;
    logic [UUID_BITS-1:0]            wb_uuid;
    logic [NW_BITS-1:0]              wb_wid;
    logic [NUM_THREADS-1:0]          wb_tmask;
    logic [31:0]                     wb_PC;
    logic [NR_BITS-1:0]              wb_rd;
    logic                            wb_eop;
    logic [DATA_BITS-1:0]            wb_data;
    logic [SRC_BITS-1:0]             wb_src;
`ifdef VX_COMMIT_PERF_EN
    logic [63:0]                     perf_commits;
    logic [63:0]                     perf_stalls;
`endif

    logic [UUID_BITS-1:0]   s_uuid  [NUM_REQS];
    logic [NW_BITS-1:0]     s_wid   [NUM_REQS];
    logic [NUM_THREADS-1:0] s_tmask [NUM_REQS];
    logic [31:0]            s_pc    [NUM_REQS];
    logic [NR_BITS-1:0]     s_rd    [NUM_REQS];
    logic [DATA_BITS-1:0]   s_data  [NUM_REQS];

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [4:0] valid;
        logic [4:0] wb;
        logic [4:0] eop;
        logic       rdy;
        logic [4:0] exp_ready;
        logic       exp_wbv;
        logic [2:0] exp_src;
    } vec_t;

    localparam int NV = 17;
    vec_t tbl [NV];

    vx_commit_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .cmt_valid    (cmt_valid),
        .cmt_ready    (cmt_ready),
        .cmt_uuid     (cmt_uuid),
        .cmt_wid      (cmt_wid),
        .cmt_tmask    (cmt_tmask),
        .cmt_PC       (cmt_PC),
        .cmt_rd       (cmt_rd),
        .cmt_wb       (cmt_wb),
        .cmt_eop      (cmt_eop),
        .cmt_data     (cmt_data),
        .wb_valid     (wb_valid),
        .wb_ready     (wb_ready),
        .wb_uuid      (wb_uuid),
        .wb_wid       (wb_wid),
        .wb_tmask     (wb_tmask),
        .wb_PC        (wb_PC),
        .wb_rd        (wb_rd),
        .wb_eop       (wb_eop),
        .wb_data      (wb_data),
        .wb_src       (wb_src)
`ifdef VX_COMMIT_PERF_EN
        ,
        .perf_commits (perf_commits),
        .perf_stalls  (perf_stalls)
`endif
    );

    always #5 clk = ~clk;

    // Pack the per-source payload arrays onto the flat DUT buses.
    always_comb begin
        cmt_uuid  = '0;
        cmt_wid   = '0;
        cmt_tmask = '0;
        cmt_PC    = '0;
        cmt_rd    = '0;
        cmt_data  = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            cmt_uuid[i*UUID_BITS +: UUID_BITS]     = s_uuid[i];
            cmt_wid[i*NW_BITS +: NW_BITS]          = s_wid[i];
            cmt_tmask[i*NUM_THREADS +: NUM_THREADS] = s_tmask[i];
            cmt_PC[i*32 +: 32]                     = s_pc[i];
            cmt_rd[i*NR_BITS +: NR_BITS]           = s_rd[i];
            cmt_data[i*DATA_BITS +: DATA_BITS]     = s_data[i];
        end
    end

    task automatic set_defaults();
        for (int i = 0; i < NUM_REQS; i++) begin
            s_uuid[i]  = UUID_BITS'(100 + i);
            s_wid[i]   = NW_BITS'(i);
            s_tmask[i] = 4'hF;
            s_pc[i]    = 32'h1000 + 32'(4 * i);
            s_rd[i]    = NR_BITS'(i + 3);
            s_data[i]  = {4{32'(i)}};
        end
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [4:0] v, input logic [4:0] wb, input logic [4:0] eop,
                                input logic rdy, input logic [4:0] er, input logic ev,
                                input logic [2:0] es);
        vec_t r;
        r.valid = v; r.wb = wb; r.eop = eop; r.rdy = rdy;
        r.exp_ready = er; r.exp_wbv = ev; r.exp_src = es;
        return r;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // round-robin among ALU, LSU, GPU
        tbl[0]  = mk(5'b10011, 5'b11111, 5'b11111, 1'b1, 5'b00001, 1'b1, 3'd0);
        tbl[1]  = mk(5'b10011, 5'b11111, 5'b11111, 1'b1, 5'b00010, 1'b1, 3'd1);
        tbl[2]  = mk(5'b10011, 5'b11111, 5'b11111, 1'b1, 5'b10000, 1'b1, 3'd4);
        tbl[3]  = mk(5'b10011, 5'b11111, 5'b11111, 1'b1, 5'b00001, 1'b1, 3'd0);
        tbl[4]  = mk(5'b10011, 5'b11111, 5'b11111, 1'b1, 5'b00010, 1'b1, 3'd1);
        tbl[5]  = mk(5'b10011, 5'b11111, 5'b11111, 1'b1, 5'b10000, 1'b1, 3'd4);
        // LSU partial beat locks; ALU must wait, even while LSU drops valid
        tbl[6]  = mk(5'b00010, 5'b11111, 5'b11101, 1'b1, 5'b00010, 1'b1, 3'd1);
        tbl[7]  = mk(5'b00001, 5'b11111, 5'b11111, 1'b1, 5'b00000, 1'b0, 3'd0);
        tbl[8]  = mk(5'b00011, 5'b11111, 5'b11111, 1'b1, 5'b00010, 1'b1, 3'd1);
        tbl[9]  = mk(5'b00001, 5'b11111, 5'b11111, 1'b1, 5'b00001, 1'b1, 3'd0);
        // backpressure: CSR non-writing beat still consumed, ALU blocked then released
        tbl[10] = mk(5'b00100, 5'b11011, 5'b11111, 1'b0, 5'b00100, 1'b1, 3'd0);
        tbl[11] = mk(5'b00001, 5'b11111, 5'b11111, 1'b0, 5'b00000, 1'b1, 3'd0);
        tbl[12] = mk(5'b00001, 5'b11111, 5'b11111, 1'b1, 5'b00001, 1'b1, 3'd0);
        tbl[13] = mk(5'b00000, 5'b11111, 5'b11111, 1'b1, 5'b00000, 1'b0, 3'd0);
        // bring rr_ptr to 4, then wrap 4 -> 0
        tbl[14] = mk(5'b01000, 5'b11111, 5'b11111, 1'b1, 5'b01000, 1'b1, 3'd3);
        tbl[15] = mk(5'b10001, 5'b11111, 5'b11111, 1'b1, 5'b10000, 1'b1, 3'd4);
        tbl[16] = mk(5'b10001, 5'b11111, 5'b11111, 1'b1, 5'b00001, 1'b1, 3'd0);

        set_defaults();
        reset     = 1'b0;
        cmt_valid = '0;
        cmt_wb    = '0;
        cmt_eop   = '0;
        wb_ready  = 1'b0;
        repeat (2) @(negedge clk);

        check("rst_wb_valid", wb_valid, 0);
        check("rst_wb_rd", wb_rd, 0);
        check("rst_wb_data", wb_data, 0);
        check("rst_wb_src", wb_src, 0);
        check("rst_ready", cmt_ready, 0);
`ifdef VX_COMMIT_PERF_EN
        check("rst_perf_commits", perf_commits, 0);
`endif
        reset = 1'b1;
        @(negedge clk);

        // single ALU beat
        s_rd[0]    = 6'd5;
        s_wid[0]   = 2'd1;
        s_tmask[0] = 4'b1010;
        s_data[0]  = {4{32'h11111111}};
        cmt_valid  = 5'b00001;
        cmt_wb     = 5'b11111;
        cmt_eop    = 5'b11111;
        wb_ready   = 1'b1;
        #1;
        check("single_ready", cmt_ready, 5'b00001);
        @(posedge clk); #1;
        check("single_wb_valid", wb_valid, 1);
        check("single_wb_rd", wb_rd, 5);
        check("single_wb_wid", wb_wid, 1);
        check("single_wb_tmask", wb_tmask, 4'b1010);
        check("single_wb_src", wb_src, 0);
        check("single_wb_eop", wb_eop, 1);
        check("single_wb_uuid", wb_uuid, 100);
        check("single_wb_pc", wb_PC, 32'h1000);
        check("single_wb_data", wb_data, {4{32'h11111111}});
`ifdef VX_COMMIT_PERF_EN
        check("single_perf_commits", perf_commits, 1);
`endif

        // output hold under wb_ready=0 with an LSU writing beat pending
        @(negedge clk);
        cmt_valid = 5'b00010;
        wb_ready  = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("hold%0d_ready", c), cmt_ready, 0);
            check($sformatf("hold%0d_wb_valid", c), wb_valid, 1);
            check($sformatf("hold%0d_wb_rd", c), wb_rd, 5);
            check($sformatf("hold%0d_wb_data", c), wb_data, {4{32'h11111111}});
            @(negedge clk);
        end

        // asynchronous reset mid-stream; rr_ptr was 1 so GPU would win without the reset
        cmt_valid = 5'b10001;
        #2;
        reset = 1'b0;
        #1;
        check("arst_wb_valid", wb_valid, 0);
        check("arst_wb_rd", wb_rd, 0);
        check("arst_ready", cmt_ready, 5'b00001);
`ifdef VX_COMMIT_PERF_EN
        check("arst_perf_commits", perf_commits, 0);
`endif
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("post_rst_ready", cmt_ready, 5'b00001);
        @(posedge clk); #1;
        check("post_rst_wb_valid", wb_valid, 1);
        check("post_rst_wb_src", wb_src, 0);

        // clean restart for the table
        @(negedge clk);
        cmt_valid = '0;
        set_defaults();
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        for (int v = 0; v < NV; v++) begin
            cmt_valid = tbl[v].valid;
            cmt_wb    = tbl[v].wb;
            cmt_eop   = tbl[v].eop;
            wb_ready  = tbl[v].rdy;
            #1;
            check($sformatf("v%0d_ready", v), cmt_ready, tbl[v].exp_ready);
            @(posedge clk); #1;
            check($sformatf("v%0d_wb_valid", v), wb_valid, tbl[v].exp_wbv);
            if (tbl[v].exp_wbv) begin
                check($sformatf("v%0d_wb_src", v), wb_src, tbl[v].exp_src);
                check($sformatf("v%0d_wb_rd", v), wb_rd, 6'(tbl[v].exp_src) + 6'd3);
            end
            @(negedge clk);
        end

`ifdef VX_COMMIT_PERF_EN
        check("tbl_perf_commits", perf_commits, 13);
        check("tbl_perf_stalls", perf_stalls, 2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vx_commit_arbiter.md
Name: vx_commit_arbiter

Overview:
- Collects completed results from the five execution units (ALU, LSU, CSR, FPU, GPU) and serialises them onto the single GPR writeback port.
- Sits at the back end of the issue pipeline, after the execution units. It is the return path for requests the dispatch stage fans out.
- Round-robin arbitration, with a lock that keeps an instruction's partial (multi-beat) writebacks contiguous.
- One registered output stage with a ready/valid handshake.

Parameters:
- NUM_REQS, 5, number of commit sources. Index 0=ALU, 1=LSU, 2=CSR, 3=FPU, 4=GPU.
- NUM_THREADS, 4, lanes per warp.
- NUM_WARPS, 4, warps per core. NW_BITS = clog2(NUM_WARPS).
- NR_BITS, 6, register index width.
- UUID_BITS, 44, instruction trace-id width.

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-low reset.
- cmt_valid  in  NUM_REQS  per-source result valid.
- cmt_ready  out  NUM_REQS  per-source accept.
- cmt_uuid  in  NUM_REQS*UUID_BITS  trace id.
- cmt_wid  in  NUM_REQS*NW_BITS  warp id.
- cmt_tmask  in  NUM_REQS*NUM_THREADS  lanes carried by this beat.
- cmt_PC  in  NUM_REQS*32  instruction PC.
- cmt_rd  in  NUM_REQS*NR_BITS  destination register.
- cmt_wb  in  NUM_REQS  1 = writes rd.
- cmt_eop  in  NUM_REQS  last beat of the instruction.
- cmt_data  in  NUM_REQS*NUM_THREADS*32  per-lane result.
- wb_valid  out  1  writeback valid.
- wb_ready  in  1  GPR port accepts.
- wb_uuid, wb_wid, wb_tmask, wb_PC, wb_rd, wb_eop, wb_data  out  (same widths as one source)  registered writeback payload.
- wb_src  out  3  index of the winning source.

Behaviour:
- Reset (reset=0, asynchronous):
  - wb_valid=0, all wb_* payload outputs=0.
  - rr_ptr=0, lock_valid=0, lock_src=0.
- Output stage: one register. can_accept = !wb_valid || wb_ready.
- Arbitration, every cycle:
  - If lock_valid, candidate = lock_src only.
  - Otherwise, candidate = first valid source at or after rr_ptr, wrapping modulo NUM_REQS.
- Grant and handshake:
  - cmt_ready[i] = (i == candidate) && cmt_valid[i] && (cmt_wb[i] ? can_accept : 1).
  - At most one cmt_ready is high per cycle.
  - Beats with wb=0 are consumed without touching the output stage. They still update the lock, pointer and counter.
- Accept (fire = cmt_valid & cmt_ready on the candidate):
  - If wb=1, the payload is loaded into the output register and wb_valid=1 next cycle. Latency is exactly 1 cycle.
  - If eop=0: lock_valid←1, lock_src←candidate.
  - If eop=1: lock_valid←0, rr_ptr←(candidate+1) mod NUM_REQS.
  - rr_ptr never changes while locked.
- Output hold: if wb_valid && !wb_ready, wb_* hold stable and every cmt_ready for a wb=1 beat is 0.
- Back-to-back: wb_ready=1 permits one accepted beat per cycle.
- No valid sources: no state change; wb_valid falls after the current beat drains.
- Locked source deasserts valid mid-instruction: stall and keep the lock. Other sources are not served.
- wrap: from rr_ptr=4, the search order is 4,0,1,2,3.
- Reset mid-beat: the beat is discarded. Upstream re-issue is outside this block.

Optional Feature:
- Macro: VX_COMMIT_PERF_EN.
- Defined:
  - Adds output perf_commits (64 bits), reset 0.
  - perf_commits increments by 1 per accepted eop=1 beat, wb or not, and wraps at 2^64.
  - Adds output perf_stalls (64 bits), reset 0. perf_stalls increments on each cycle where any cmt_valid is high and no beat fires.
- Undefined: neither port exists and there is no counter logic.

Decomposition:
- Shared package holds:
  - source index constants CMT_ALU=0, CMT_LSU=1, CMT_CSR=2, CMT_FPU=3, CMT_GPU=4.
  - packed typedef cmt_beat_t {uuid, wid, tmask, PC, rd, wb, eop, data}.
- Sub-module vx_rr_lock_arbiter: rr_ptr, lock and candidate selection, with a parameterised requester count. The top level keeps the output register and payload muxing.

Test Plan:
- Single ALU beat {wid=1, rd=5, wb=1, eop=1, data=0x11...} with wb_ready=1: wb_valid on the next cycle, wb_rd=5, wb_src=0, rr_ptr=1.
- ALU, LSU and GPU valid continuously with wb_ready=1: grants go 0,1,4,0,1,4 with one per cycle.
- LSU beat tmask=0011 eop=0, then ALU valid, then LSU beat tmask=1100 eop=1: both LSU beats are written back consecutively and the ALU is granted only after.
- wb_ready=0 for 3 cycles while wb_valid=1: payload stable, all wb=1 cmt_ready=0. A CSR beat with wb=0, eop=1 is still consumed.
- rr_ptr=4 with sources 0 and 4 valid: source 4 granted first, then source 0.
- reset pulsed low mid-stream: wb_valid=0 immediately, and the first post-reset grant goes to the lowest valid index. With VX_COMMIT_PERF_EN, perf_commits returns to 0.
